vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA display fetch and a host write port.
- Display fetch is driven by the pixel_x/pixel_y/video_on outputs of vga_sync.
- Frame buffer holds 160x120 words of COLOR_W bits; each word is replicated to a 4x4 block on the 640x480 screen.
- Display fetch always wins the RAM; host writes are buffered in a one-entry holding register and issued in free cycles.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_fetch_sched.sv | 61 ++++++
 rtl/vga_fb_arbiter.sv | 115 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared timing constants, frame-buffer geometry and helper types for the
//   VGA frame-buffer arbiter.
//
//   The frame buffer stores one COLOR_W word per 4x4 screen block, giving a
//   160x120 grid. Words are laid out row-major: addr = row*160 + col.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Display timing, in pixel clocks and lines
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  // Frame-buffer geometry
  localparam int FB_COLS  = H_ACTIVE / 4;
  localparam int FB_ROWS  = V_ACTIVE / 4;
  localparam int FB_WORDS = FB_COLS * FB_ROWS;

  // Datapath widths
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 3;
  localparam int PIX_W    = 10;

  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [PIX_W-1:0]   pix_t;

  // One buffered host write
  typedef struct packed {
    logic     valid;
    fb_addr_t addr;
    color_t   data;
  } wr_req_t;

  // What the single RAM port does in a given cycle
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_FETCH = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_DROP  = 2'd3   // pending write is out of range, retire it silently
  } mem_op_e;

  // row*160 + col without a multiplier: 160 = 128 + 32.
  // row < 120 and col < 160 keep the result at or below 19199.
  function automatic fb_addr_t fb_addr(input logic [6:0] row,
                                       input logic [7:0] col);
    fb_addr_t r;
    r = fb_addr_t'(row);
    return (r << 7) + (r << 5) + fb_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_fetch_sched.sv
// ---------------------------------------------------------------------------
// vga_fetch_sched
//   Decides, from the current raster position, whether this cycle is a
//   display fetch cycle and which frame-buffer word to read.
//
//   A word is read once per 4-pixel group, two cycles ahead of the group's
//   first pixel (phase 2 of the previous group). Group 0 of a line is
//   fetched at the tail of the previous line (pixel_x == H_TOTAL-2).
//
// Ports
//   pixel_x     in   current column from vga_sync
//   pixel_y     in   current line from vga_sync
//   fetch_cycle out  RAM port is claimed by the display this cycle
//   fetch_addr  out  word address to read (0 when not fetching)
// ---------------------------------------------------------------------------
module vga_fetch_sched
  import vga_pkg::*;
(
  input  logic [PIX_W-1:0]  pixel_x,
  input  logic [PIX_W-1:0]  pixel_y,
  output logic              fetch_cycle,
  output logic [ADDR_W-1:0] fetch_addr
);

  logic [1:0]       phase;
  logic [PIX_W-1:0] ny;
  logic             mid_line;
  logic             line_wrap;
  logic [6:0]       row;
  logic [7:0]       col;

  always_comb begin
    phase = pixel_x[1:0];

    // Line that follows the current one, wrapping at the end of the frame
    ny = (pixel_y == PIX_W'(V_TOTAL - 1)) ? '0 : pixel_y + PIX_W'(1);

    // Next group still lies on this visible line
    mid_line  = (phase == 2'd2) &&
                (pixel_x < PIX_W'(H_ACTIVE - 2)) &&
                (pixel_y < PIX_W'(V_ACTIVE));

    // Prefetch group 0 of the next line, if that line is visible
    line_wrap = (phase == 2'd2) &&
                (pixel_x == PIX_W'(H_TOTAL - 2)) &&
                (ny < PIX_W'(V_ACTIVE));

    fetch_cycle = mid_line | line_wrap;

    if (line_wrap) begin
      row = 7'(ny >> 2);
      col = '0;
    end else begin
      row = 7'(pixel_y >> 2);
      col = 8'(pixel_x >> 2) + 8'd1;
    end

    fetch_addr = fetch_cycle ? fb_addr(row, col) : '0;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port synchronous frame-buffer RAM between the VGA
//   display fetch and a host write port. The display always wins; host
//   writes sit in a one-entry holding register and go out in the next
//   cycle that is not a fetch cycle. Writes beyond the frame buffer are
//   accepted and then dropped without touching the RAM.
//
// Ports
//   clk          in   pixel clock (pixel_x steps by one per cycle)
//   reset        in   synchronous, active-high
//   pixel_x/y    in   raster position from vga_sync
//   video_on     in   active-area flag from vga_sync
//   host_valid   in   host write request
//   host_ready   out  holding register empty
//   host_addr    in   word address, row*160+col
//   host_wdata   in   write data
//   mem_addr     out  RAM address
//   mem_we       out  RAM write enable
//   mem_wdata    out  RAM write data
//   mem_rdata    in   RAM read data, one cycle after the address
//   rgb          out  pixel colour, 0 outside the active area
//   frame_start  out  one-cycle pulse the cycle after (0,0)
// ---------------------------------------------------------------------------
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pixel_x,
  input  logic [PIX_W-1:0]   pixel_y,
  input  logic               video_on,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [COLOR_W-1:0] host_wdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start
);

  logic     fetch_cycle;
  fb_addr_t fetch_addr;
  wr_req_t  pend;
  color_t   cur_word;
  mem_op_e  mem_op;
  logic     pend_fire;

  vga_fetch_sched u_sched (
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .fetch_cycle (fetch_cycle),
    .fetch_addr  (fetch_addr)
  );

  assign host_ready = ~pend.valid;

  // Port arbitration. Reset masks everything so a write held in the
  // register when reset arrives can never reach the RAM.
  always_comb begin
    mem_op = MEM_IDLE;
    if (reset)
      mem_op = MEM_IDLE;
    else if (fetch_cycle)
      mem_op = MEM_FETCH;
    else if (pend.valid)
      mem_op = (pend.addr < ADDR_W'(FB_WORDS)) ? MEM_WRITE : MEM_DROP;
  end

  // Holding register retires whether the write is performed or dropped
  assign pend_fire = (mem_op == MEM_WRITE) || (mem_op == MEM_DROP);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (mem_op)
      MEM_FETCH: mem_addr = fetch_addr;
      MEM_WRITE: begin
        mem_addr  = pend.addr;
        mem_we    = 1'b1;
        mem_wdata = pend.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend        <= '0;
      cur_word    <= '0;
      frame_start <= 1'b0;
    end else begin
      // Accept and retire never coincide: accept needs the register empty,
      // retire needs it full.
      if (host_valid && host_ready)
        pend <= '{valid: 1'b1, addr: host_addr, data: host_wdata};
      else if (pend_fire)
        pend.valid <= 1'b0;

      // Read data for the fetch issued at phase 2 lands during phase 3;
      // latch it so it covers the whole next 4-pixel group.
      if (pixel_x[1:0] == 2'd3)
        cur_word <= mem_rdata;

      frame_start <= (pixel_x == '0) && (pixel_y == '0);
    end
  end

  assign rgb = video_on ? cur_word : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Drives raster positions and host writes, models the frame-buffer RAM,
//   and checks the arbiter against a reference built from the display and
//   write-buffer rules. Expected writes are queued on acceptance and popped
//   by the monitor when the DUT presents mem_we.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int NWORDS = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on;
  logic        host_valid;
  logic        host_ready;
  logic [14:0] host_addr;
  logic [2:0]  host_wdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic [2:0]  rgb;
  logic        frame_start;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_exp_t;

  int      cyc = 0;
  int      contig = 0;       // cycles stepped without a position jump
  int      n_chk = 0;
  int      n_pass = 0;
  bit      fin_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] init_val(input int i);
    if (i == 1) return 3'd5;
    return 3'((i * 13 + (i / 160) * 7 + 3) % 8);
  endfunction

  // Reference: which word the display needs now. Reads happen two pixels
  // ahead of each 4-pixel group; -1 when nothing is read.
  function automatic int model_fetch(input int x, input int y);
    int nx, ny;
    if (x % 4 != 2) return -1;
    nx = x + 2;
    ny = y;
    if (nx >= 800) begin
      nx = 0;
      ny = (y + 1) % 525;
    end
    if (nx >= 640 || ny >= 480) return -1;
    return (ny / 4) * 160 + nx / 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  // Frame-buffer RAM: synchronous read, one cycle latency
  logic [2:0] ram [NWORDS];
  initial begin
    for (int i = 0; i < NWORDS; i++) ram[i] = init_val(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rdata <= (int'(mem_addr) < NWORDS) ? ram[mem_addr] : 3'd0;
      if (mem_we && int'(mem_addr) < NWORDS) ram[mem_addr] = mem_wdata;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [2:0] shadow [NWORDS];
    wr_exp_t    wq [$];
    wr_exp_t    e;
    bit         rst_prev = 0;
    bit         busy_chk = 0;
    bit         fs_prev = 0;
    int         last_acc = -100;
    int         fa, x, y;
    for (int i = 0; i < NWORDS; i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      x = int'(pixel_x);
      y = int'(pixel_y);
      if (fin_req) begin
        chk("queue_drained", wq.size(), 0);
        fin_req = 0;
      end
      if (reset) begin
        wq.delete();
        chk("reset_we", int'(mem_we), 0);
        if (rst_prev) begin
          chk("reset_ready", int'(host_ready), 1);
          chk("reset_addr", int'(mem_addr), 0);
          chk("reset_rgb", int'(rgb), 0);
          chk("reset_fs", int'(frame_start), 0);
        end
        rst_prev = 1;
        busy_chk = 0;
        fs_prev  = 0;
      end else begin
        if (rst_prev) chk("ready_after_reset", int'(host_ready), 1);
        if (busy_chk) chk("ready_busy", int'(host_ready), 0);
        if (!host_ready && cyc - last_acc > 2) chk("ready_return", int'(host_ready), 1);

        // A buffered write must have gone out within two cycles
        if (wq.size() > 0 && cyc - wq[0].cyc >= 2 && !mem_we) begin
          chk("wr_missing", int'(mem_we), 1);
          void'(wq.pop_front());
        end

        fa = model_fetch(x, y);
        if (fa >= 0) begin
          chk("fetch_addr", int'(mem_addr), fa);
          chk("fetch_we", int'(mem_we), 0);
        end else if (mem_we) begin
          if (wq.size() == 0) chk("spurious_we", int'(mem_we), 0);
          else begin
            e = wq.pop_front();
            chk("wr_addr", int'(mem_addr), e.addr);
            chk("wr_data", int'(mem_wdata), e.data);
            chk("wr_latency_ok", int'(cyc - e.cyc <= 2), 1);
            shadow[e.addr] = 3'(e.data);
          end
        end else begin
          chk("idle_addr", int'(mem_addr), 0);
          chk("idle_wdata", int'(mem_wdata), 0);
        end

        if (!video_on) chk("rgb_blank", int'(rgb), 0);
        else if (contig >= (x % 4) + 2)
          chk("rgb", int'(rgb), int'(shadow[(y / 4) * 160 + x / 4]));

        chk("frame_start", int'(frame_start), int'(fs_prev));
        fs_prev = (x == 0 && y == 0);

        if (host_valid && host_ready) begin
          last_acc = cyc;
          busy_chk = 1;
          if (int'(host_addr) < NWORDS)
            wq.push_back('{addr: int'(host_addr), data: int'(host_wdata), cyc: cyc});
        end else busy_chk = 0;
        rst_prev = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step the raster from (x0,y0) for n cycles. inj selects one cycle for a
  // directed host write; rnd adds random host traffic to rows 60..119 and
  // past the end of the buffer, away from the rows being displayed.
  task automatic run(input int x0, input int y0, input int n, input bit rnd,
                     input int inj, input int ia, input int id);
    int x, y;
    x = x0;
    y = y0;
    for (int i = 0; i < n; i++) begin
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = (x < 640 && y < 480);
      contig   = (i == 0) ? 0 : contig + 1;
      host_valid = 1'b0;
      if (i == inj) begin
        host_valid = 1'b1;
        host_addr  = 15'(ia);
        host_wdata = 3'(id);
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        host_valid = 1'b1;
        host_addr  = ($urandom_range(0, 4) == 0) ? 15'($urandom_range(19200, 32767))
                                                 : 15'($urandom_range(9600, 19199));
        host_wdata = 3'($urandom);
      end
      tick();
      x++;
      if (x == 800) begin
        x = 0;
        y = (y == 524) ? 0 : y + 1;
      end
    end
    host_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    host_valid = 1'b1;
    host_addr  = 15'd50;
    host_wdata = 3'd7;
    pixel_x    = 10'd5;
    pixel_y    = 10'd0;
    video_on   = 1'b1;
    contig     = 0;
    repeat (3) @(posedge clk);
    #1;
    reset      = 1'b0;
    host_valid = 1'b0;

    // Frame wrap into line 0, whole line 0, and group fetch boundaries
    run(790, 524, 900, 0, -1, 0, 0);
    run(780, 3, 30, 0, -1, 0, 0);
    run(790, 479, 20, 0, -1, 0, 0);
    // Write to word 100 at pixel_x=1: blocked by the fetch at 2, lands at 3
    run(0, 1, 420, 0, 1, 100, 6);
    // Out-of-range write is accepted and dropped
    run(0, 2, 40, 0, 11, 19200, 5);

    // Reset while a write is pending: it must never reach the RAM
    pixel_x = 10'd6; pixel_y = 10'd2; video_on = 1'b1; contig = 0;
    host_valid = 1'b1; host_addr = 15'd10000; host_wdata = 3'd3;
    tick();
    host_valid = 1'b0;
    reset = 1'b1;
    pixel_x = 10'd7;
    tick();
    pixel_x = 10'd8;
    tick();
    reset = 1'b0;

    for (int r = 0; r < 20; r++)
      run($urandom_range(0, 799), $urandom_range(0, 230), $urandom_range(40, 400),
          1, -1, 0, 0);
    run(700, $urandom_range(520, 524), 600, 1, -1, 0, 0);

    // Park off-screen and let the holding register drain
    pixel_x = 10'd700; pixel_y = 10'd500; video_on = 1'b0; contig = 0;
    repeat (4) tick();
    fin_req = 1;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
